ks_pipe_subtractor: RTL and testbench

KS_PIPE_SUBTRACTOR -- requirements
Module: ks_pipe_subtractor

---
 rtl/ks_pipe_subtractor.sv | 117 +++++++++++
 tb/tb_ks_pipe_subtractor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_pipe_subtractor.sv
// Three-stage pipelined Kogge-Stone subtractor with valid/ready flow control.
// Computes a + ~b + ~bin; the borrow-out is the inverted carry-out.
module ks_pipe_subtractor #(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int HALF   = (LEVELS + 1) / 2;

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_cin, s1_amsb;

  logic [WIDTH-1:0] s2_g, s2_gp, s2_p;
  logic             s2_cin, s2_amsb;

  logic [WIDTH-1:0] g_m, p_m;
  logic [WIDTH-1:0] g_f, p_f;
  logic [WIDTH-1:0] diff_c;
  logic             bout_c, ovf_c;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // Carry-in folded into bit 0 so every group G spans down to the cin
  always_comb begin
    g_m    = s1_g;
    p_m    = s1_p;
    g_m[0] = s1_g[0] | (s1_p[0] & s1_cin);
    for (int k = 0; k < HALF; k++) begin
      for (int i = WIDTH - 1; i >= VALENCY ** k; i--) begin
        g_m[i] = g_m[i] | (p_m[i] & g_m[i - VALENCY ** k]);
        p_m[i] = p_m[i] & p_m[i - VALENCY ** k];
      end
    end
  end

  always_comb begin
    g_f = s2_g;
    p_f = s2_gp;
    for (int k = HALF; k < LEVELS; k++) begin
      for (int i = WIDTH - 1; i >= VALENCY ** k; i--) begin
        g_f[i] = g_f[i] | (p_f[i] & g_f[i - VALENCY ** k]);
        p_f[i] = p_f[i] & p_f[i - VALENCY ** k];
      end
    end
  end

  // p msb is 0 exactly when the operand sign bits differ
  assign diff_c = s2_p ^ {g_f[WIDTH-2:0], s2_cin};
  assign bout_c = ~g_f[WIDTH-1];
  assign ovf_c  = ~s2_p[WIDTH-1] & (diff_c[WIDTH-1] ^ s2_amsb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_g    <= '0;
      s1_p    <= '0;
      s1_cin  <= 1'b0;
      s1_amsb <= 1'b0;
      s2_g    <= '0;
      s2_gp   <= '0;
      s2_p    <= '0;
      s2_cin  <= 1'b0;
      s2_amsb <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (ld1) begin
        v1      <= in_valid;
        s1_g    <= a & ~b;
        s1_p    <= a ^ ~b;
        s1_cin  <= ~bin;
        s1_amsb <= a[WIDTH-1];
      end
      if (ld2) begin
        v2      <= v1;
        s2_g    <= g_m;
        s2_gp   <= p_m;
        s2_p    <= s1_p;
        s2_cin  <= s1_cin;
        s2_amsb <= s1_amsb;
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          diff <= diff_c;
          bout <= bout_c;
          ovf  <= ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_ks_pipe_subtractor.sv
// Bench for ks_pipe_subtractor: directed corner cases, back-pressure,
// mid-stream reset and a randomized stream against an arithmetic model.
module tb_ks_pipe_subtractor;

  localparam int W = 16;
  localparam int N_RAND = 10000;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         bin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  ks_pipe_subtractor #(.WIDTH(W), .VALENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t         q[$];
  int           n_chk;
  int           n_fail;
  int           n_out;
  logic         got_in;
  logic         got_out;
  logic         hold_chk;
  logic [W+1:0] hold_val;

  function automatic exp_t ref_sub(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic c);
    exp_t   e;
    logic [W:0] r;
    longint sd;
    longint smax;
    longint smin;
    r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    sd   = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.ov = (sd > smax) || (sd < smin);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle of scoreboarded traffic; transfers decided just before the edge
  task automatic step(input logic iv, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input logic ibin,
                      input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    if (hold_chk) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", {bout, ovf, diff}, hold_val);
    end
    chk("in_ready", in_ready, !(q.size() == 3 && !ordy));
    got_in  = iv && in_ready;
    got_out = out_valid && ordy;
    if (got_out) begin
      chk("out_expected", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("bout", bout, e.bo);
        chk("ovf", ovf, e.ov);
        n_out++;
      end
    end
    if (got_in) q.push_back(ref_sub(ia, ib, ibin));
    hold_chk = out_valid && !ordy;
    hold_val = {bout, ovf, diff};
  endtask

  // Lone operation on an empty pipe: checks exact 3-edge latency
  task automatic send_one(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input logic [W-1:0] ed,
                          input logic eb, input logic eo);
    @(negedge clk);
    a         = ia;
    b         = ib;
    bin       = ibin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk("one_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_edge1", out_valid, 1'b0);
    @(negedge clk);
    #1 chk("lat_edge2", out_valid, 1'b0);
    @(negedge clk);
    #1 chk("lat_edge3", out_valid, 1'b1);
    chk("one_diff", diff, ed);
    chk("one_bout", bout, eb);
    chk("one_ovf", ovf, eo);
  endtask

  logic [W-1:0] bp_a[5];
  logic [W-1:0] bp_b[5];

  initial begin
    int k;
    int emitted;
    int first;
    int last;
    int base;
    int tx_in;
    int ci;
    logic [W-1:0] ra, rb;
    logic         rc;

    n_chk    = 0;
    n_fail   = 0;
    n_out    = 0;
    hold_chk = 1'b0;
    hold_val = '0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_diff", diff, '0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_one(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    send_one(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send_one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_one(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    send_one(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    send_one(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // back-pressure: five offered with the sink stalled
    bp_a = '{16'h0010, 16'h8000, 16'h0003, 16'hFFFF, 16'h1234};
    bp_b = '{16'h0001, 16'h7FFF, 16'h0005, 16'hFFFF, 16'h4321};
    k = 0;
    for (int c = 0; c < 8; c++) begin
      ci = (k < 5) ? k : 4;
      step(k < 5, bp_a[ci], bp_b[ci], ci[0], 1'b0);
      if (got_in) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    emitted = 0;
    first   = -1;
    last    = -1;
    for (int c = 0; c < 20 && emitted < 5; c++) begin
      ci = (k < 5) ? k : 4;
      step(k < 5, bp_a[ci], bp_b[ci], ci[0], 1'b1);
      if (got_in) k++;
      if (got_out) begin
        if (emitted == 0) first = c;
        last = c;
        emitted++;
      end
    end
    chk("bp_emitted", emitted, 5);
    chk("bp_no_gaps", last - first, 4);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // reset with results in flight
    step(1'b1, 16'h0007, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 16'h0009, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_diff", diff, '0);
    q.delete();
    hold_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0, '0, '0, 1'b0, 1'b1);
    send_one(16'd5, 16'd3, 1'b0, 16'd2, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // randomized stream
    base  = n_out;
    tx_in = 0;
    ra    = rnd_op();
    rb    = rnd_op();
    rc    = 1'($urandom_range(0, 1));
    for (int c = 0; c < 60000 && (n_out - base) < N_RAND; c++) begin
      step((tx_in < N_RAND) && ($urandom_range(0, 9) < 7), ra, rb, rc,
           $urandom_range(0, 9) < 7);
      if (got_in) begin
        tx_in++;
        ra = rnd_op();
        rb = rnd_op();
        rc = 1'($urandom_range(0, 1));
      end
    end
    chk("rand_count", n_out - base, N_RAND);
    chk("rand_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
